acq_sequencer: RTL and testbench
================================

ACQ_SEQUENCER -- requirements
Module: acq_sequencer

Interface
REQ-001 Parameter PRE_W, default 12: width of pre-trigger sample count.
REQ-002 Parameter POST_W, default 16: width of post-trigger sample count.
REQ-003 Parameter FLUSH_CYC, default 4: number of cycles the FIFO reset is held.
REQ-004 clk  in  1  sample clock (dclk domain, 250 MHz); the block SHALL use this single clock.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 arm  in  1  level; start an acquisition while high.
REQ-007 acq_clear  in  1  abort request; highest priority.
REQ-008 force_trig  in  1  level from the CPU register; its rising edge forces a trigger.
REQ-009 trig_hit  in  1  single-cycle trigger qualifier from the comparator.
REQ-010 pre_trig_len  in  PRE_W  samples to hold before the trigger.
REQ-011 post_trig_len  in  POST_W  samples to capture after the trigger.
REQ-012 arm_rd_done  in  1  CPU finished reading the FIFO.
REQ-013 fifo_rst  out  1  FIFO reset.
REQ-014 wr_en  out  1  FIFO write enable.
REQ-015 drop_en  out  1  FIFO read-and-discard of the oldest sample (circular pre-trigger buffer).
REQ-016 trigged_flag  out  1  a trigger has occurred in the current acquisition.
REQ-017 fifo_full  out  1  acquisition complete; data is ready for the CPU.
REQ-018 wait_cnt  out  32  samples spent in WAIT_TRIG, saturating.
REQ-019 state  out  3  current state, for the status register.

Function
REQ-020 States SHALL be IDLE, FLUSH, PRE, WAIT_TRIG, POST and DONE; all outputs SHALL be registered.
REQ-021 acq_clear=1 in any state SHALL force IDLE on the next edge, clearing all counters and outputs.
REQ-022 IDLE: when arm=1, go to FLUSH; otherwise stay in IDLE.
REQ-023 FLUSH: fifo_rst=1 for exactly FLUSH_CYC cycles, then go to PRE; wait_cnt and trigged_flag SHALL clear on entry.
REQ-024 PRE: wr_en=1 every cycle; after pre_trig_len writes, go to WAIT_TRIG; with pre_trig_len=0, go directly from FLUSH to WAIT_TRIG.
REQ-025 PRE: trig_hit and force_trig edges SHALL be ignored, so the trigger position is never inside an unfilled buffer.
REQ-026 WAIT_TRIG: wr_en=1 and drop_en=1 every cycle, so FIFO occupancy stays at pre_trig_len.
REQ-027 WAIT_TRIG: wait_cnt SHALL increment by 1 per cycle and saturate at 32'hFFFF_FFFF.
REQ-028 WAIT_TRIG: trig_hit=1 or a force_trig rising edge SHALL move to POST and set trigged_flag.
REQ-029 The triggering sample SHALL be the first POST write; drop_en=0 in that cycle.
REQ-030 POST: wr_en=1; after post_trig_len writes, go to DONE; with post_trig_len=0, go directly from WAIT_TRIG to DONE.
REQ-031 DONE: wr_en=0, drop_en=0, fifo_full=1; trigged_flag and wait_cnt SHALL hold.
REQ-032 DONE: arm_rd_done=1 SHALL move to IDLE and clear fifo_full; if arm is still high, the next acquisition starts on the following cycle.
REQ-033 pre_trig_len and post_trig_len SHALL be sampled on FLUSH entry and held for the whole acquisition.
REQ-034 A force_trig edge and trig_hit in the same cycle SHALL count as one trigger.
REQ-035 arm deasserted mid-acquisition SHALL NOT abort it; only acq_clear aborts.
REQ-036 Latency: input change to output effect SHALL be 1 cycle; there is no combinational input-to-output path.

Reset
REQ-037 rst=1 SHALL asynchronously force state=IDLE and every output and counter to 0.
REQ-038 Release of rst SHALL be synchronised to clk inside the block, so the first arm is accepted no earlier than 2 cycles after release.

Structure
REQ-039 Package acq_pkg SHALL hold the state encoding (IDLE=0, FLUSH=1, PRE=2, WAIT_TRIG=3, POST=4, DONE=5) and the FLUSH_CYC default.
REQ-040 The force_trig rising-edge detector SHALL be sub-module acq_edge_det: 1 register, 1-cycle pulse out.
REQ-041 There SHALL be one shared sample counter of width max(PRE_W, POST_W), reused across FLUSH, PRE and POST.

Verification
REQ-042 pre=8, post=16, arm pulse, trig_hit at WAIT cycle 5 -> fifo_rst for 4 cycles, 8 PRE writes, wait_cnt=5, 16 POST writes, fifo_full=1, total wr_en=29.
REQ-043 pre=0, post=0, arm, force_trig 0->1 -> states FLUSH, WAIT_TRIG, DONE with zero POST writes and trigged_flag=1.
REQ-044 trig_hit pulsed during PRE (pre=10) -> ignored; WAIT_TRIG is entered and no trigger occurs until the next trig_hit.
REQ-045 acq_clear asserted in POST at write 3 of 16 -> IDLE next cycle, all outputs 0, no fifo_full.
REQ-046 DONE with arm held high, arm_rd_done pulse -> IDLE for 1 cycle, then FLUSH with fifo_rst=1 and fifo_full=0.
REQ-047 wait_cnt preloaded near 32'hFFFF_FFFE, no trigger for 4 cycles -> wait_cnt saturates at 32'hFFFF_FFFF; rst asserted mid-WAIT -> immediate IDLE with all outputs 0.

Source files
------------

// File: rtl/acq_pkg.sv
// Shared definitions for the acquisition sequencer: state encoding and defaults.
package acq_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FLUSH     = 3'd1,
    PRE       = 3'd2,
    WAIT_TRIG = 3'd3,
    POST      = 3'd4,
    DONE      = 3'd5
  } acq_state_t;

  localparam int FLUSH_CYC_DEF = 4;

  // Width of the shared sample counter: wide enough for either length.
  function automatic int max_w(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/acq_edge_det.sv
// Rising-edge detector: one history register, one-cycle pulse on a 0->1 change.
module acq_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic pulse
);

  logic din_q;

  // Remember the previous level of the input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      din_q <= 1'b0;
    end else begin
      din_q <= din;
    end
  end

  assign pulse = din & ~din_q;

endmodule

// File: rtl/acq_sequencer.sv
// Acquisition sequencer: flushes the sample FIFO, fills a circular pre-trigger
// window, waits for a trigger, captures the post-trigger samples and hands the
// buffer to the CPU. WAIT_CNT_INIT is the value wait_cnt restarts from on each
// acquisition (0 in normal use; a nonzero preload exercises saturation).
module acq_sequencer
  import acq_pkg::*;
#(
  parameter int          PRE_W         = 12,
  parameter int          POST_W        = 16,
  parameter int          FLUSH_CYC     = FLUSH_CYC_DEF,
  parameter logic [31:0] WAIT_CNT_INIT = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              arm,
  input  logic              acq_clear,
  input  logic              force_trig,
  input  logic              trig_hit,
  input  logic [PRE_W-1:0]  pre_trig_len,
  input  logic [POST_W-1:0] post_trig_len,
  input  logic              arm_rd_done,
  output logic              fifo_rst,
  output logic              wr_en,
  output logic              drop_en,
  output logic              trigged_flag,
  output logic              fifo_full,
  output logic [31:0]       wait_cnt,
  output logic [2:0]        state
);

  localparam int CNT_W = max_w(PRE_W, POST_W);

  acq_state_t        st;
  logic [CNT_W-1:0]  cnt;
  logic [PRE_W-1:0]  pre_len_q;
  logic [POST_W-1:0] post_len_q;
  logic [1:0]        rst_sync;
  logic              run;
  logic              force_pulse;
  logic              trig;

  acq_edge_det u_force_edge (
    .clk   (clk),
    .rst   (rst),
    .din   (force_trig),
    .pulse (force_pulse)
  );

  // A comparator hit and a forced edge in the same cycle are one trigger.
  assign trig  = trig_hit | force_pulse;
  assign run   = ~rst_sync[1];
  assign state = st;

  // Stretch reset release by two clocks so the FSM leaves reset synchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rst_sync <= 2'b11;
    end else begin
      rst_sync <= {rst_sync[0], 1'b0};
    end
  end

  // Sequencer FSM; every output is set here for the state being entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st           <= IDLE;
      cnt          <= {CNT_W{1'b0}};
      pre_len_q    <= {PRE_W{1'b0}};
      post_len_q   <= {POST_W{1'b0}};
      fifo_rst     <= 1'b0;
      wr_en        <= 1'b0;
      drop_en      <= 1'b0;
      trigged_flag <= 1'b0;
      fifo_full    <= 1'b0;
      wait_cnt     <= 32'h0000_0000;
    end else if (!run || acq_clear) begin
      st           <= IDLE;
      cnt          <= {CNT_W{1'b0}};
      pre_len_q    <= {PRE_W{1'b0}};
      post_len_q   <= {POST_W{1'b0}};
      fifo_rst     <= 1'b0;
      wr_en        <= 1'b0;
      drop_en      <= 1'b0;
      trigged_flag <= 1'b0;
      fifo_full    <= 1'b0;
      wait_cnt     <= 32'h0000_0000;
    end else begin
      fifo_rst <= 1'b0;
      wr_en    <= 1'b0;
      drop_en  <= 1'b0;
      case (st)
        IDLE: begin
          if (arm) begin
            st           <= FLUSH;
            fifo_rst     <= 1'b1;
            cnt          <= CNT_W'(FLUSH_CYC - 1);
            pre_len_q    <= pre_trig_len;
            post_len_q   <= post_trig_len;
            wait_cnt     <= WAIT_CNT_INIT;
            trigged_flag <= 1'b0;
          end else begin
            st <= IDLE;
          end
        end
        FLUSH: begin
          if (cnt != {CNT_W{1'b0}}) begin
            cnt      <= cnt - CNT_W'(1);
            fifo_rst <= 1'b1;
          end else if (pre_len_q == {PRE_W{1'b0}}) begin
            st      <= WAIT_TRIG;
            wr_en   <= 1'b1;
            drop_en <= 1'b1;
          end else begin
            st    <= PRE;
            wr_en <= 1'b1;
            cnt   <= CNT_W'(pre_len_q) - CNT_W'(1);
          end
        end
        PRE: begin
          // Triggers are deliberately not looked at until the window is full.
          wr_en <= 1'b1;
          if (cnt != {CNT_W{1'b0}}) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            st      <= WAIT_TRIG;
            drop_en <= 1'b1;
          end
        end
        WAIT_TRIG: begin
          if (wait_cnt != 32'hFFFF_FFFF) begin
            wait_cnt <= wait_cnt + 32'd1;
          end else begin
            wait_cnt <= wait_cnt;
          end
          if (trig) begin
            trigged_flag <= 1'b1;
            if (post_len_q == {POST_W{1'b0}}) begin
              st        <= DONE;
              fifo_full <= 1'b1;
            end else begin
              // Triggering sample is the first post write; keep the oldest.
              st    <= POST;
              wr_en <= 1'b1;
              cnt   <= CNT_W'(post_len_q) - CNT_W'(1);
            end
          end else begin
            wr_en   <= 1'b1;
            drop_en <= 1'b1;
          end
        end
        POST: begin
          if (cnt != {CNT_W{1'b0}}) begin
            cnt   <= cnt - CNT_W'(1);
            wr_en <= 1'b1;
          end else begin
            st        <= DONE;
            fifo_full <= 1'b1;
          end
        end
        DONE: begin
          if (arm_rd_done) begin
            st        <= IDLE;
            fifo_full <= 1'b0;
          end else begin
            st <= DONE;
          end
        end
        default: begin
          st <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_acq_sequencer.sv
// Scoreboard bench for acq_sequencer: expected results are queued as stimulus
// is driven and compared when the acquisition finishes.
module tb_acq_sequencer;
  import acq_pkg::*;

  logic        clk = 1'b0;
  logic        rst, arm, acq_clear, force_trig, trig_hit, arm_rd_done;
  logic [11:0] pre_trig_len;
  logic [15:0] post_trig_len;
  logic        fifo_rst, wr_en, drop_en, trigged_flag, fifo_full;
  logic [31:0] wait_cnt;
  logic [2:0]  state;
  logic        s_fifo_rst, s_wr_en, s_drop_en, s_trigged_flag, s_fifo_full;
  logic [31:0] s_wait_cnt;
  logic [2:0]  s_state;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;
  exp_t exp_q[$];

  int n_cmp = 0;
  int n_err = 0;
  int n_wr, n_drop, n_frst, n_pre_wr, n_post_wr;
  logic [2:0] trace[$];
  logic [2:0] last_st;

  acq_sequencer dut (
    .clk(clk), .rst(rst), .arm(arm), .acq_clear(acq_clear),
    .force_trig(force_trig), .trig_hit(trig_hit),
    .pre_trig_len(pre_trig_len), .post_trig_len(post_trig_len),
    .arm_rd_done(arm_rd_done), .fifo_rst(fifo_rst), .wr_en(wr_en),
    .drop_en(drop_en), .trigged_flag(trigged_flag), .fifo_full(fifo_full),
    .wait_cnt(wait_cnt), .state(state)
  );

  acq_sequencer #(.WAIT_CNT_INIT(32'hFFFF_FFFE)) dut_sat (
    .clk(clk), .rst(rst), .arm(arm), .acq_clear(acq_clear),
    .force_trig(force_trig), .trig_hit(trig_hit),
    .pre_trig_len(pre_trig_len), .post_trig_len(post_trig_len),
    .arm_rd_done(arm_rd_done), .fifo_rst(s_fifo_rst), .wr_en(s_wr_en),
    .drop_en(s_drop_en), .trigged_flag(s_trigged_flag), .fifo_full(s_fifo_full),
    .wait_cnt(s_wait_cnt), .state(s_state)
  );

  always #5 clk = ~clk;

  // Tally registered outputs once per cycle, away from the active edge.
  always @(negedge clk) begin
    n_wr   = n_wr + int'(wr_en);
    n_drop = n_drop + int'(drop_en);
    n_frst = n_frst + int'(fifo_rst);
    if (wr_en && state == PRE)  n_pre_wr  = n_pre_wr + 1;
    if (wr_en && state == POST) n_post_wr = n_post_wr + 1;
    if (state != last_st) begin
      trace.push_back(state);
      last_st = state;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    exp_q.push_back(e);
  endtask

  task automatic sb_check(input logic [31:0] obs);
    exp_t e;
    if (exp_q.size() == 0) begin
      e.tag = "sb_underflow";
      e.val = ~obs;
    end else begin
      e = exp_q.pop_front();
    end
    check_val(e.tag, obs, e.val);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_mon();
    n_wr = 0; n_drop = 0; n_frst = 0; n_pre_wr = 0; n_post_wr = 0;
    trace.delete();
    last_st = state;
  endtask

  task automatic wait_state(input string tag, input logic [2:0] s, input int budget);
    for (int i = 0; i < budget && state !== s; i++) tick();
    check_val(tag, {29'd0, state}, {29'd0, s});
  endtask

  task automatic wait_full(input string tag, input int budget);
    for (int i = 0; i < budget && fifo_full !== 1'b1; i++) tick();
    check_val(tag, {31'd0, fifo_full}, 32'd1);
  endtask

  task automatic rd_done();
    arm_rd_done = 1'b1;
    tick();
    arm_rd_done = 1'b0;
  endtask

  initial begin
    rst = 1'b1; arm = 1'b0; acq_clear = 1'b0; force_trig = 1'b0;
    trig_hit = 1'b0; arm_rd_done = 1'b0;
    pre_trig_len = 12'd8; post_trig_len = 16'd16;
    n_wr = 0; n_drop = 0; n_frst = 0; n_pre_wr = 0; n_post_wr = 0;
    last_st = 3'd0;
    repeat (3) tick();
    check_val("rst_state", {29'd0, state}, 32'd0);
    check_val("rst_outs", {27'd0, fifo_rst, wr_en, drop_en, trigged_flag, fifo_full}, 32'd0);
    check_val("rst_wait", wait_cnt, 32'd0);

    // Reset release: arm is held off for two synchroniser cycles.
    arm = 1'b1;
    rst = 1'b0;
    tick(); tick();
    check_val("sync_hold", {29'd0, state}, {29'd0, IDLE});
    clr_mon();

    // Basic acquisition: pre 8, post 16, trigger in WAIT cycle 5.
    sb_push("t1_frst", 32'd4);
    sb_push("t1_pre_wr", 32'd8);
    sb_push("t1_wait_cnt", 32'd5);
    sb_push("t1_drop", 32'd5);
    sb_push("t1_post_wr", 32'd16);
    sb_push("t1_wr_total", 32'd29);
    sb_push("t1_trigged", 32'd1);
    tick();
    check_val("t1_flush", {29'd0, state}, {29'd0, FLUSH});
    arm = 1'b0;
    wait_state("t1_wait", WAIT_TRIG, 40);
    repeat (4) tick();
    trig_hit = 1'b1;
    tick();
    trig_hit = 1'b0;
    check_val("t1_post", {29'd0, state}, {29'd0, POST});
    check_val("t1_first_post_drop", {31'd0, drop_en}, 32'd0);
    wait_full("t1_full", 40);
    sb_check(n_frst);
    sb_check(n_pre_wr);
    sb_check(wait_cnt);
    sb_check(n_drop);
    sb_check(n_post_wr);
    sb_check(n_wr);
    sb_check({31'd0, trigged_flag});
    rd_done();
    check_val("t1_idle", {29'd0, state}, {29'd0, IDLE});
    check_val("t1_full_clr", {31'd0, fifo_full}, 32'd0);

    // Zero-length windows with a forced trigger.
    pre_trig_len = 12'd0; post_trig_len = 16'd0;
    clr_mon();
    sb_push("t2_trace_len", 32'd3);
    sb_push("t2_tr0", {29'd0, FLUSH});
    sb_push("t2_tr1", {29'd0, WAIT_TRIG});
    sb_push("t2_tr2", {29'd0, DONE});
    sb_push("t2_post_wr", 32'd0);
    sb_push("t2_pre_wr", 32'd0);
    arm = 1'b1;
    tick();
    arm = 1'b0;
    wait_state("t2_wait", WAIT_TRIG, 20);
    force_trig = 1'b1;
    tick();
    check_val("t2_done", {29'd0, state}, {29'd0, DONE});
    check_val("t2_flags", {30'd0, trigged_flag, fifo_full}, 32'd3);
    force_trig = 1'b0;
    tick();
    sb_check(trace.size());
    for (int i = 0; i < 3; i++) sb_check((i < trace.size()) ? {29'd0, trace[i]} : 32'hFFFF_FFFF);
    sb_check(n_post_wr);
    sb_check(n_pre_wr);
    rd_done();

    // Triggers during PRE are ignored; lengths are latched at FLUSH entry.
    pre_trig_len = 12'd10; post_trig_len = 16'd4;
    clr_mon();
    sb_push("t3_pre_wr", 32'd10);
    sb_push("t3_post_wr", 32'd4);
    arm = 1'b1;
    tick();
    arm = 1'b0;
    pre_trig_len = 12'd3; post_trig_len = 16'd9;
    wait_state("t3_pre", PRE, 20);
    tick(); tick();
    trig_hit = 1'b1; force_trig = 1'b1;
    tick();
    trig_hit = 1'b0;
    check_val("t3_pre_ign", {29'd0, state}, {29'd0, PRE});
    wait_state("t3_wait", WAIT_TRIG, 20);
    repeat (6) tick();
    check_val("t3_still_wait", {29'd0, state}, {29'd0, WAIT_TRIG});
    check_val("t3_no_trig", {31'd0, trigged_flag}, 32'd0);
    trig_hit = 1'b1;
    tick();
    trig_hit = 1'b0;
    check_val("t3_post", {29'd0, state}, {29'd0, POST});
    check_val("t3_trigged", {31'd0, trigged_flag}, 32'd1);
    wait_full("t3_full", 40);
    sb_check(n_pre_wr);
    sb_check(n_post_wr);
    force_trig = 1'b0;
    rd_done();

    // Abort in POST at write 3.
    pre_trig_len = 12'd2; post_trig_len = 16'd16;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    wait_state("t4_wait", WAIT_TRIG, 20);
    trig_hit = 1'b1;
    tick();
    trig_hit = 1'b0;
    tick(); tick();
    check_val("t4_post", {29'd0, state}, {29'd0, POST});
    acq_clear = 1'b1;
    tick();
    acq_clear = 1'b0;
    check_val("t4_idle", {29'd0, state}, {29'd0, IDLE});
    check_val("t4_outs", {27'd0, fifo_rst, wr_en, drop_en, trigged_flag, fifo_full}, 32'd0);
    check_val("t4_wait_cnt", wait_cnt, 32'd0);
    tick();
    check_val("t4_stay_idle", {29'd0, state}, {29'd0, IDLE});

    // Re-arm straight out of DONE while arm stays high.
    pre_trig_len = 12'd1; post_trig_len = 16'd1;
    arm = 1'b1;
    tick();
    wait_state("t5_wait", WAIT_TRIG, 20);
    trig_hit = 1'b1;
    tick();
    trig_hit = 1'b0;
    wait_full("t5_full", 20);
    tick();
    check_val("t5_done_hold", {29'd0, state}, {29'd0, DONE});
    rd_done();
    check_val("t5_idle", {29'd0, state}, {29'd0, IDLE});
    check_val("t5_full_clr", {31'd0, fifo_full}, 32'd0);
    tick();
    check_val("t5_flush", {29'd0, state}, {29'd0, FLUSH});
    check_val("t5_frst", {30'd0, fifo_rst, fifo_full}, 32'd2);
    arm = 1'b0;
    acq_clear = 1'b1;
    tick();
    acq_clear = 1'b0;

    // wait_cnt saturation, then asynchronous reset mid-WAIT.
    pre_trig_len = 12'd2; post_trig_len = 16'd4;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    wait_state("t6_wait", WAIT_TRIG, 20);
    check_val("t6_preload", s_wait_cnt, 32'hFFFF_FFFE);
    repeat (4) tick();
    check_val("t6_sat", s_wait_cnt, 32'hFFFF_FFFF);
    check_val("t6_count", wait_cnt, 32'd4);
    check_val("t6_state", {29'd0, state}, {29'd0, WAIT_TRIG});
    #2;
    rst = 1'b1;
    #1;
    check_val("t6_rst_state", {29'd0, state}, 32'd0);
    check_val("t6_rst_outs", {27'd0, fifo_rst, wr_en, drop_en, trigged_flag, fifo_full}, 32'd0);
    check_val("t6_rst_wait", wait_cnt, 32'd0);
    check_val("t6_rst_sat", s_wait_cnt, 32'd0);
    rst = 1'b0;
    repeat (3) tick();

    check_val("sb_leftover", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
